// File: rtl/selector_color_pkg.sv
// rtl/selector_color_pkg.sv - Shared widths, reset level and channel indices for selector_color.
package selector_color_pkg;

  localparam int NIVEL_W = 4;
  localparam logic [NIVEL_W-1:0] NIVEL_RESET = 4'hF;
  localparam int NUM_CANALES = 3;

  typedef enum logic [1:0] {
    CANAL_R = 2'd0,
    CANAL_G = 2'd1,
    CANAL_B = 2'd2
  } canal_t;

endpackage

// File: rtl/antirrebote.sv
// rtl/antirrebote.sv - Button synchroniser, debouncer and one-cycle press strobe.
// Auto-repeat while held is built only with SELECTOR_AUTOREPEAT_EN defined.
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic reloj,
  input  logic resetM,
  input  logic i_boton,
  output logic o_pulso
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef SELECTOR_AUTOREPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  logic [1:0]       r_sinc;
  logic             r_estable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flanco;
  logic             w_repite;

  // r_sinc[1] is the synchronised button; any disagreement must persist to be accepted
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_sinc    <= 2'b00;
      r_estable <= 1'b0;
      r_cnt     <= '0;
      r_flanco  <= 1'b0;
    end else begin
      r_sinc   <= {r_sinc[0], i_boton};
      r_flanco <= 1'b0;
      if (r_sinc[1] == r_estable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_estable <= r_sinc[1];
        r_cnt     <= '0;
        r_flanco  <= r_sinc[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  generate
    if (REPEAT_EN && (REPEAT_CYCLES > 1)) begin : g_repite
      localparam int REP_W = $clog2(REPEAT_CYCLES);
      localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
      logic [REP_W-1:0] r_rep;
      logic             r_rep_pulso;

      always_ff @(posedge reloj) begin
        if (resetM || !r_estable) begin
          r_rep       <= '0;
          r_rep_pulso <= 1'b0;
        end else if (r_rep == REP_MAX) begin
          r_rep       <= '0;
          r_rep_pulso <= 1'b1;
        end else begin
          r_rep       <= r_rep + 1'b1;
          r_rep_pulso <= 1'b0;
        end
      end
      assign w_repite = r_rep_pulso;
    end else begin : g_sin_repite
      assign w_repite = 1'b0;
    end
  endgenerate

  assign o_pulso = r_flanco | w_repite;

endmodule

// File: rtl/selector_color.sv
// rtl/selector_color.sv - Debounced per-channel colour levels, published only in vertical blanking.
// SELECTOR_AUTOREPEAT_EN enables auto-repeat inside antirrebote.
module selector_color
  import selector_color_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP            = 1,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic               reloj,
  input  logic               resetM,
  input  logic               boton_r,
  input  logic               boton_g,
  input  logic               boton_b,
  input  logic               v_on,
  output logic [NIVEL_W-1:0] nivel_r,
  output logic [NIVEL_W-1:0] nivel_g,
  output logic [NIVEL_W-1:0] nivel_b,
  output logic               pulso_r,
  output logic               pulso_g,
  output logic               pulso_b,
  output logic               cambio
);

  localparam logic [NIVEL_W-1:0] PASO = NIVEL_W'(STEP);

  logic [NUM_CANALES-1:0] w_boton;
  logic [NUM_CANALES-1:0] w_pulso;
  logic [NIVEL_W-1:0]     r_sombra [NUM_CANALES];
  logic [NIVEL_W-1:0]     r_nivel  [NUM_CANALES];
  logic                   r_cambio;
  logic                   w_difiere;

  assign w_boton[CANAL_R] = boton_r;
  assign w_boton[CANAL_G] = boton_g;
  assign w_boton[CANAL_B] = boton_b;

  generate
    for (genvar c = 0; c < NUM_CANALES; c++) begin : g_canal
      antirrebote #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
      ) u_antirrebote (
        .reloj  (reloj),
        .resetM (resetM),
        .i_boton(w_boton[c]),
        .o_pulso(w_pulso[c])
      );
    end
  endgenerate

  always_comb begin
    w_difiere = 1'b0;
    for (int c = 0; c < NUM_CANALES; c++) begin
      if (r_sombra[c] != r_nivel[c]) w_difiere = 1'b1;
    end
  end

  // Presses accumulate in the shadow; the copy to the published level happens only in blanking
  always_ff @(posedge reloj) begin
    if (resetM) begin
      for (int c = 0; c < NUM_CANALES; c++) begin
        r_sombra[c] <= NIVEL_RESET;
        r_nivel[c]  <= NIVEL_RESET;
      end
      r_cambio <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CANALES; c++) begin
        if (w_pulso[c]) r_sombra[c] <= r_sombra[c] + PASO;
        if (!v_on) r_nivel[c] <= r_sombra[c];
      end
      r_cambio <= !v_on && w_difiere;
    end
  end

  assign nivel_r = r_nivel[CANAL_R];
  assign nivel_g = r_nivel[CANAL_G];
  assign nivel_b = r_nivel[CANAL_B];
  assign pulso_r = w_pulso[CANAL_R];
  assign pulso_g = w_pulso[CANAL_G];
  assign pulso_b = w_pulso[CANAL_B];
  assign cambio  = r_cambio;

endmodule

// File: tb/tb_selector_color.sv
// tb/tb_selector_color.sv - Randomised self-checking bench for selector_color.
module tb_selector_color;

  localparam int D    = 4;
  localparam int STEP = 1;
  localparam int R    = 10;

  logic       reloj = 1'b0;
  logic       resetM = 1'b1;
  logic       boton_r = 1'b0, boton_g = 1'b0, boton_b = 1'b0;
  logic       v_on = 1'b1;
  logic [3:0] nivel_r, nivel_g, nivel_b;
  logic       pulso_r, pulso_g, pulso_b, cambio;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_p [3];
  int cnt_cambio;

  always #5 reloj = ~reloj;

  selector_color #(
    .DEBOUNCE_CYCLES(D),
    .STEP           (STEP),
    .REPEAT_CYCLES  (R)
  ) dut (
    .reloj  (reloj),
    .resetM (resetM),
    .boton_r(boton_r),
    .boton_g(boton_g),
    .boton_b(boton_b),
    .v_on   (v_on),
    .nivel_r(nivel_r),
    .nivel_g(nivel_g),
    .nivel_b(nivel_b),
    .pulso_r(pulso_r),
    .pulso_g(pulso_g),
    .pulso_b(pulso_b),
    .cambio (cambio)
  );

  task automatic clear_counts();
    for (int c = 0; c < 3; c++) cnt_p[c] = 0;
    cnt_cambio = 0;
  endtask

  task automatic tick();
    @(posedge reloj);
    #1;
    cnt_p[0]   += int'(pulso_r);
    cnt_p[1]   += int'(pulso_g);
    cnt_p[2]   += int'(pulso_b);
    cnt_cambio += int'(cambio);
  endtask

  task automatic set_buttons(input logic [2:0] mask);
    boton_r = mask[0];
    boton_g = mask[1];
    boton_b = mask[2];
  endtask

  task automatic do_reset();
    set_buttons(3'b000);
    v_on   = 1'b1;
    resetM = 1'b1;
    repeat (3) tick();
    resetM = 1'b0;
    clear_counts();
  endtask

  task automatic press(input logic [2:0] mask);
    set_buttons(mask);
    repeat (8) tick();
    set_buttons(3'b000);
    repeat (8) tick();
  endtask

  task automatic glitch(input logic [2:0] mask, input int len);
    set_buttons(mask);
    repeat (len) tick();
    set_buttons(3'b000);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    int first;
    boton_r = 1'b1;
    v_on    = 1'b1;
    resetM  = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({nivel_r, nivel_g, nivel_b} !== 12'hFFF) begin
      n_fail++;
      $display("FAIL reset_niveles: got %h expected fff", {nivel_r, nivel_g, nivel_b});
    end
    n_checks++;
    if ({pulso_r, pulso_g, pulso_b, cambio} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0000", {pulso_r, pulso_g, pulso_b, cambio});
    end
    resetM = 1'b0;
    clear_counts();
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (pulso_r && first < 0) first = i;
    end
    n_checks++;
    if (first !== 6) begin
      n_fail++;
      $display("FAIL reset_held_latency: got %0d expected 6", first);
    end
    n_checks++;
    if (cnt_p[0] !== 1) begin
      n_fail++;
      $display("FAIL reset_held_count: got %0d expected 1", cnt_p[0]);
    end
    boton_r = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (nivel_r !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_active_hold: got %h expected f", nivel_r);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      boton_g = (k % 2 == 0);
      repeat (2) tick();
    end
    boton_g = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (cnt_p[1] !== 0) begin
      n_fail++;
      $display("FAIL bounce_reject: got %0d strobes expected 0", cnt_p[1]);
    end
    boton_g = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (cnt_p[1] !== 1) begin
      n_fail++;
      $display("FAIL bounce_accept: got %0d strobes expected 1", cnt_p[1]);
    end
    boton_g = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (cnt_p[1] !== 1) begin
      n_fail++;
      $display("FAIL bounce_release: got %0d strobes expected 1", cnt_p[1]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    v_on = 1'b0;
    repeat (2) tick();
    press(3'b100);
    n_checks++;
    if (nivel_b !== 4'h0 || cnt_cambio !== 1) begin
      n_fail++;
      $display("FAIL wrap_first: got nivel_b=%h cambios=%0d expected 0/1", nivel_b, cnt_cambio);
    end
    press(3'b100);
    n_checks++;
    if (nivel_b !== 4'h1 || cnt_cambio !== 2) begin
      n_fail++;
      $display("FAIL wrap_second: got nivel_b=%h cambios=%0d expected 1/2", nivel_b, cnt_cambio);
    end
    n_checks++;
    if ({nivel_r, nivel_g} !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap_others: got %h expected ff", {nivel_r, nivel_g});
    end
  endtask

  task automatic test_blanking_gate();
    do_reset();
    repeat (3) press(3'b001);
    n_checks++;
    if (nivel_r !== 4'hF || cnt_cambio !== 0) begin
      n_fail++;
      $display("FAIL gate_hold: got nivel_r=%h cambios=%0d expected f/0", nivel_r, cnt_cambio);
    end
    v_on = 1'b0;
    tick();
    n_checks++;
    if (nivel_r !== 4'h2 || cambio !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_publish: got nivel_r=%h cambio=%b expected 2/1", nivel_r, cambio);
    end
    repeat (4) tick();
    n_checks++;
    if (cnt_cambio !== 1) begin
      n_fail++;
      $display("FAIL gate_cambio_count: got %0d expected 1", cnt_cambio);
    end
  endtask

  task automatic test_simultaneous();
    bit mixed;
    mixed = 1'b0;
    do_reset();
    v_on = 1'b0;
    set_buttons(3'b111);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) set_buttons(3'b000);
      tick();
      if (!(nivel_r == nivel_g && nivel_g == nivel_b)) mixed = 1'b1;
    end
    n_checks++;
    if ({nivel_r, nivel_g, nivel_b} !== 12'h000 || mixed) begin
      n_fail++;
      $display("FAIL simul_levels: got %h mixed=%b expected 000/0", {nivel_r, nivel_g, nivel_b}, mixed);
    end
    n_checks++;
    if (cnt_cambio !== 1) begin
      n_fail++;
      $display("FAIL simul_cambio: got %0d expected 1", cnt_cambio);
    end
  endtask

  task automatic test_random();
    int n [3];
    int rounds, nz, exp_cambio;
    logic [2:0] mask;
    logic [3:0] got, want;
    bit blank;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      blank = (it % 2 == 1);
      v_on  = !blank;
      for (int c = 0; c < 3; c++) n[c] = 0;
      nz     = 0;
      rounds = $urandom_range(1, 6);
      for (int r = 0; r < rounds; r++) begin
        mask = 3'($urandom_range(0, 7));
        if (mask != 3'b000) nz++;
        if ($urandom_range(0, 1) == 1) glitch(mask, $urandom_range(1, 3));
        press(mask);
        for (int c = 0; c < 3; c++) if (mask[c]) n[c]++;
      end
      if (!blank) begin
        n_checks++;
        if ({nivel_r, nivel_g, nivel_b} !== 12'hFFF) begin
          n_fail++;
          $display("FAIL rand_active_hold it%0d: got %h expected fff", it, {nivel_r, nivel_g, nivel_b});
        end
      end
      v_on = 1'b0;
      repeat (4) tick();
      for (int c = 0; c < 3; c++) begin
        want = 4'((15 + n[c] * STEP) % 16);
        got  = (c == 0) ? nivel_r : (c == 1) ? nivel_g : nivel_b;
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL rand_nivel it%0d ch%0d: got %h expected %h", it, c, got, want);
        end
      end
      exp_cambio = blank ? nz : ((n[0] + n[1] + n[2]) > 0 ? 1 : 0);
      n_checks++;
      if (cnt_cambio !== exp_cambio) begin
        n_fail++;
        $display("FAIL rand_cambio it%0d: got %0d expected %0d", it, cnt_cambio, exp_cambio);
      end
    end
  endtask

  task automatic test_autorepeat();
    int waited, total, expected;
`ifdef SELECTOR_AUTOREPEAT_EN
    expected = 4;
`else
    expected = 1;
`endif
    do_reset();
    boton_g = 1'b1;
    waited  = 0;
    while (!pulso_g && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (!pulso_g) begin
      n_fail++;
      $display("FAIL repeat_first_timeout: got no pulso_g after %0d cycles expected one", waited);
    end
    total = 1;
    for (int i = 1; i < 40; i++) begin
      tick();
      total += int'(pulso_g);
    end
    n_checks++;
    if (total !== expected) begin
      n_fail++;
      $display("FAIL repeat_count: got %0d strobes expected %0d", total, expected);
    end
    boton_g = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_wrap();
    test_blanking_gate();
    test_simultaneous();
    test_random();
    test_autorepeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
